// File: rtl/pyramid_row_tracker_if.sv
// pyramid_row_tracker_if: upstream count stream plus the record valid/ready channel.
interface pyramid_row_tracker_if #(
    parameter int CW   = 4,
    parameter int IDXW = 4
);
    logic [CW-1:0]   in_count;
    logic            in_row_end;
    logic            in_pyr_end;
    logic            out_valid;
    logic            out_ready;
    logic [IDXW-1:0] out_row_idx;
    logic [CW:0]     out_row_len;
    logic            out_last;
    modport master (
        output in_count, in_row_end, in_pyr_end, out_ready,
        input  out_valid, out_row_idx, out_row_len, out_last
    );
    modport slave (
        input  in_count, in_row_end, in_pyr_end, out_ready,
        output out_valid, out_row_idx, out_row_len, out_last
    );
endinterface

// File: rtl/pyramid_row_tracker.sv
// pyramid_row_tracker: turns rows into FIFO-buffered records; define PYR_TRACK_CHECK_EN to build the sequence checker.
module pyramid_row_tracker #(
    parameter int CW    = 4,
    parameter int IDXW  = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pyramid_row_tracker_if.slave bus,
    output logic                 overflow_o,
    output logic                 seq_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = IDXW + CW + 2;
    typedef enum logic {SYNC, RUN} state_t;
    state_t          state_q;
    logic [CW-1:0]   prev_q;
    logic            pyr_end_q;
    logic [IDXW-1:0] row_idx_q, row_idx_d;
    logic [AW:0]     wr_q, rd_q, wr_d, rd_d, cnt_d;
    logic [RW-1:0]   mem_q [DEPTH];
    logic [RW-1:0]   head_q, head_d, rec;
    logic            valid_q, ovf_q, ovf_d;
    logic            run, pyr_rise, push, pop, full, push_ok;
    always_comb begin
        run       = state_q == RUN;
        pyr_rise  = bus.in_pyr_end & ~pyr_end_q;
        push      = run & bus.in_row_end;
        pop       = valid_q & bus.out_ready;
        full      = (wr_q - rd_q) == (AW+1)'(DEPTH);
        push_ok   = push & (~full | pop);
        rec       = {row_idx_q, {1'b0, prev_q} + (CW+1)'(1), pyr_rise};
        wr_d      = wr_q + (AW+1)'(push_ok);
        rd_d      = rd_q + (AW+1)'(pop);
        cnt_d     = wr_d - rd_d;
        // the new record becomes head only when it lands in the slot the read pointer moves to
        head_d    = cnt_d == '0 ? head_q
                  : (push_ok && wr_q[AW-1:0] == rd_d[AW-1:0]) ? rec
                  : mem_q[rd_d[AW-1:0]];
        row_idx_d = !push ? row_idx_q : pyr_rise ? '0 : row_idx_q + IDXW'(1);
        ovf_d     = ovf_q | (push & full & ~pop);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SYNC;
            prev_q    <= '0;
            pyr_end_q <= 1'b0;
            row_idx_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            head_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= RUN;
            prev_q    <= bus.in_count;
            pyr_end_q <= bus.in_pyr_end;
            row_idx_q <= row_idx_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            head_q    <= head_d;
            valid_q   <= cnt_d != '0;
            ovf_q     <= ovf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= rec;
    end
`ifdef PYR_TRACK_CHECK_EN
    logic err_q, err_d;
    always_comb begin
        err_d = err_q | (run & (bus.in_row_end ? bus.in_count != '0
                                               : bus.in_count != prev_q + CW'(1)));
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else err_q <= err_d;
    end
    assign seq_err_o = err_q;
`else
    assign seq_err_o = 1'b0;
`endif
    assign bus.out_valid = valid_q;
    assign {bus.out_row_idx, bus.out_row_len, bus.out_last} = head_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_pyramid_row_tracker.sv
// tb_pyramid_row_tracker: directed scenarios against hand-computed records and flags.
module tb_pyramid_row_tracker;
    logic clk = 1'b0;
    logic reset;
    logic overflow, seq_err;
    int n_cmp = 0;
    int n_err = 0;
`ifdef PYR_TRACK_CHECK_EN
    logic exp_err = 1'b1;
`else
    logic exp_err = 1'b0;
`endif
    always #5 clk = ~clk;
    pyramid_row_tracker_if #(.CW(4), .IDXW(4)) bus ();
    pyramid_row_tracker #(.CW(4), .IDXW(4), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .overflow_o(overflow), .seq_err_o(seq_err)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [3:0] c, input logic re, input logic pe);
        bus.in_count = c;
        bus.in_row_end = re;
        bus.in_pyr_end = pe;
    endtask
    task automatic apply_reset;
        reset = 1'b1;
        bus.out_ready = 1'b0;
        drive(4'd0, 1'b0, 1'b0);
        tick;
        tick;
        reset = 1'b0;
    endtask
    task automatic sync_start;
        drive(4'd0, 1'b1, 1'b0);
        tick;
    endtask
    task automatic test_reset;
        apply_reset;
        reset = 1'b1;
        tick;
        n_cmp++; if ({bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last} !== 11'd0) begin n_err++; $display("FAIL reset_outputs got %h want 000", {bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last}); end
        n_cmp++; if ({overflow, seq_err} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {overflow, seq_err}); end
        reset = 1'b0;
        sync_start;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL sync_no_push got valid=%b want 0", bus.out_valid); end
        drive(4'd0, 1'b1, 1'b0);
        tick;
        n_cmp++; if ({bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last} !== {1'b1, 4'd0, 5'd1, 1'b0}) begin n_err++; $display("FAIL first_run_push got %h want %h", {bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last}, {1'b1, 4'd0, 5'd1, 1'b0}); end
    endtask
    task automatic test_single_row;
        apply_reset;
        bus.out_ready = 1'b1;
        sync_start;
        for (int i = 1; i < 16; i++) begin drive(4'(i), 1'b0, 1'b0); tick; end
        drive(4'd0, 1'b1, 1'b0);
        tick;
        n_cmp++; if ({bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last} !== {1'b1, 4'd0, 5'd16, 1'b0}) begin n_err++; $display("FAIL single_row got %h want %h", {bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last}, {1'b1, 4'd0, 5'd16, 1'b0}); end
        n_cmp++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL single_row_seq_err got %b want 0", seq_err); end
    endtask
    task automatic test_full_pyramid;
        logic [10:0] want;
        apply_reset;
        bus.out_ready = 1'b1;
        sync_start;
        for (int k = 0; k < 16; k++) begin
            for (int i = 1; i < 16 - k; i++) begin drive(4'(i), 1'b0, 1'b0); tick; end
            drive(4'd0, 1'b1, k == 15);
            tick;
            want = {1'b1, 4'(k), 5'(16 - k), k == 15};
            n_cmp++; if ({bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last} !== want) begin n_err++; $display("FAIL pyramid_row%0d got %h want %h", k, {bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last}, want); end
        end
        drive(4'd1, 1'b0, 1'b1);
        tick;
        for (int i = 2; i < 16; i++) begin drive(4'(i), 1'b0, 1'b0); tick; end
        drive(4'd0, 1'b1, 1'b0);
        tick;
        n_cmp++; if ({bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last} !== {1'b1, 4'd0, 5'd16, 1'b0}) begin n_err++; $display("FAIL pyramid_next got %h want %h", {bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last}, {1'b1, 4'd0, 5'd16, 1'b0}); end
        n_cmp++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL pyramid_seq_err got %b want 0", seq_err); end
    endtask
    task automatic test_back_pressure;
        apply_reset;
        sync_start;
        for (int n = 1; n <= 5; n++) begin
            drive(4'd0, 1'b1, 1'b0);
            tick;
            if (n == 1) begin
                n_cmp++; if ({bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last} !== {1'b1, 4'd0, 5'd1, 1'b0}) begin n_err++; $display("FAIL bp_first got %h want %h", {bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last}, {1'b1, 4'd0, 5'd1, 1'b0}); end
            end
            n_cmp++; if (overflow !== (n == 5)) begin n_err++; $display("FAIL bp_overflow_row%0d got %b want %b", n, overflow, n == 5); end
        end
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n_cmp++; if ({bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last} !== {1'b1, 4'(j), 5'd1, 1'b0}) begin n_err++; $display("FAIL bp_drain%0d got %h want %h", j, {bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last}, {1'b1, 4'(j), 5'd1, 1'b0}); end
            drive(4'(j + 1), 1'b0, 1'b0);
            tick;
        end
        n_cmp++; if ({bus.out_valid, bus.out_row_idx} !== {1'b0, 4'd3}) begin n_err++; $display("FAIL bp_empty_hold got %h want %h", {bus.out_valid, bus.out_row_idx}, {1'b0, 4'd3}); end
    endtask
    task automatic test_full_push_pop;
        apply_reset;
        sync_start;
        for (int n = 0; n < 4; n++) begin drive(4'd0, 1'b1, 1'b0); tick; end
        bus.out_ready = 1'b1;
        drive(4'd0, 1'b1, 1'b0);
        tick;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pp_overflow got %b want 0", overflow); end
        for (int j = 1; j <= 4; j++) begin
            n_cmp++; if ({bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last} !== {1'b1, 4'(j), 5'd1, 1'b0}) begin n_err++; $display("FAIL full_pp_drain%0d got %h want %h", j, {bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last}, {1'b1, 4'(j), 5'd1, 1'b0}); end
            drive(4'(j), 1'b0, 1'b0);
            tick;
        end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL full_pp_empty got valid=%b want 0", bus.out_valid); end
    endtask
    task automatic test_seq_error;
        apply_reset;
        drive(4'd0, 1'b0, 1'b0);
        tick;
        drive(4'd1, 1'b0, 1'b0);
        tick;
        n_cmp++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL seq_ok got %b want 0", seq_err); end
        drive(4'd3, 1'b0, 1'b0);
        tick;
        n_cmp++; if (seq_err !== exp_err) begin n_err++; $display("FAIL seq_jump got %b want %b", seq_err, exp_err); end
        drive(4'd4, 1'b0, 1'b0);
        tick;
        drive(4'd0, 1'b1, 1'b0);
        tick;
        n_cmp++; if (seq_err !== exp_err) begin n_err++; $display("FAIL seq_sticky got %b want %b", seq_err, exp_err); end
        reset = 1'b1;
        #1;
        n_cmp++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL seq_reset got %b want 0", seq_err); end
        tick;
        reset = 1'b0;
    endtask
    task automatic test_reset_mid_row;
        apply_reset;
        sync_start;
        drive(4'd0, 1'b1, 1'b0);
        tick;
        drive(4'd0, 1'b1, 1'b0);
        tick;
        drive(4'd1, 1'b0, 1'b0);
        tick;
        n_cmp++; if ({bus.out_valid, bus.out_row_idx} !== {1'b1, 4'd0}) begin n_err++; $display("FAIL mid_queued got %h want %h", {bus.out_valid, bus.out_row_idx}, {1'b1, 4'd0}); end
        reset = 1'b1;
        #1;
        n_cmp++; if ({bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last, overflow} !== 12'd0) begin n_err++; $display("FAIL mid_async got %h want 000", {bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last, overflow}); end
        tick;
        reset = 1'b0;
        sync_start;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_sync got valid=%b want 0", bus.out_valid); end
        drive(4'd1, 1'b0, 1'b0);
        tick;
        drive(4'd2, 1'b0, 1'b0);
        tick;
        drive(4'd0, 1'b1, 1'b0);
        tick;
        n_cmp++; if ({bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last} !== {1'b1, 4'd0, 5'd3, 1'b0}) begin n_err++; $display("FAIL mid_first_row got %h want %h", {bus.out_valid, bus.out_row_idx, bus.out_row_len, bus.out_last}, {1'b1, 4'd0, 5'd3, 1'b0}); end
    endtask
    initial begin
        reset = 1'b1;
        bus.out_ready = 1'b0;
        drive(4'd0, 1'b0, 1'b0);
        test_reset;
        test_single_row;
        test_full_pyramid;
        test_back_pressure;
        test_full_push_pop;
        test_seq_error;
        test_reset_mid_row;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pyramid_row_tracker.md
# pyramid_row_tracker

Downstream consumer of the pyramid counter stage. It samples the counter value, row-end pulse and pyramid-end pulse every cycle and turns each completed row into a record: row index, row length, last-row flag. Records are buffered in a small FIFO and drained over a valid/ready interface. An optional checker flags illegal count sequences from the upstream stage.

## Interface
- CW, 4: width of upstream count.
- IDXW, 4: width of row index.
- DEPTH, 4: record FIFO depth, power of two, ≥2.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- in_count  in  CW  upstream count value.
- in_row_end  in  1  upstream row-end pulse; high in the first cycle of a new row, when in_count is 0.
- in_pyr_end  in  1  upstream pyramid-end indication; may stay high for more than one cycle.
- out_valid  out  1  FIFO head record available.
- out_ready  in  1  consumer accepts head record.
- out_row_idx  out  IDXW  index of row within current pyramid.
- out_row_len  out  CW+1  row length in cycles (1..2^CW).
- out_last  out  1  record closes a pyramid.
- overflow  out  1  sticky; a record was dropped because the FIFO was full.
- seq_err  out  1  sticky; the upstream sequence violated the count rules.

## Operation
- Reset values:
  - Outputs: out_valid=0, out_row_idx=0, out_row_len=0, out_last=0, overflow=0, seq_err=0.
  - Internal state: FSM=SYNC, prev_count=0, row_idx=0, pyr_end_d=0, FIFO empty.
- FSM SYNC:
  - On the first post-reset cycle: load prev_count←in_count, pyr_end_d←in_pyr_end, go to RUN.
  - No record is pushed and no check is made, even if in_row_end=1.
- FSM RUN: every cycle prev_count←in_count and pyr_end_d←in_pyr_end.
- Row close: when in_row_end=1 in RUN, push the record {row_idx, prev_count+1, pyr_rise}.
  - pyr_rise = in_pyr_end & ~pyr_end_d.
  - Length is computed in CW+1 bits, so prev_count=2^CW−1 gives 2^CW.
  - Back-to-back in_row_end cycles give length 1 each.
- Row index:
  - row_idx increments (mod 2^IDXW) on each push with pyr_rise=0.
  - row_idx clears to 0 on each push with pyr_rise=1.
  - row_idx updates even when the record is dropped on overflow.
- A pyr_rise without in_row_end in the same cycle is ignored.
- FIFO:
  - out_* show the head entry; when empty the outputs hold their last values and out_valid=0.
  - Pop occurs when out_valid & out_ready.
  - Push while full with a simultaneous pop succeeds.
  - Push while full without a pop drops the new record and sets overflow=1.
- Checker (RUN only, when compiled in):
  - If in_row_end=1, require in_count==0.
  - Otherwise require in_count==prev_count+1 mod 2^CW.
  - Any mismatch sets seq_err=1.
- Sticky flags clear only on reset.
- Reset mid-operation: everything returns to reset values immediately and the FIFO contents are discarded.

## Timing
- Record latency: a record pushed at the edge that samples in_row_end=1 appears at the head of an empty FIFO, with out_valid=1, directly after that edge.
- Throughput: one push and one pop per cycle, sustained.
- out_valid depends only on FIFO state, never combinationally on out_ready.
- Flags: overflow and seq_err rise directly after the offending sampling edge.

## Configuration
- PYR_TRACK_CHECK_EN defined: sequence checker present; seq_err behaves as above.
- PYR_TRACK_CHECK_EN undefined: checker logic absent; seq_err tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Single row:
  - Stimulus: after reset, drive count 0..15, then in_row_end=1 with count=0; out_ready=1.
  - Required: one record idx=0, len=16, last=0; seq_err=0.
- Full pyramid:
  - Stimulus: rows of length 16,15,…,1; in_pyr_end rises with the in_row_end that closes the length-1 row and is held for 2 cycles.
  - Required: 16 records with idx 0..15 and len 16..1; only the final record has last=1; the next row's record has idx=0.
- Back-pressure:
  - Stimulus: out_ready=0 while 5 rows of length 1 complete, DEPTH=4.
  - Required: out_valid=1 after the first row; overflow=1 after the 5th.
  - Required: then out_ready=1 drains exactly idx 0..3, len=1.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, out_ready=1, in_row_end=1 in the same cycle.
  - Required: no drop, overflow stays 0, occupancy stays 4.
- Sequence error (macro defined):
  - Stimulus: drive count 0,1,3.
  - Required: seq_err=1 after the edge sampling 3, held until reset.
  - Same stimulus with the macro undefined: seq_err=0.
- Reset mid-row:
  - Stimulus: assert reset with 2 records queued.
  - Required: out_valid=0 immediately; the first row-end after release yields idx=0.
